// File: rtl/dec_stage_pipe.sv
// Decode stage: controller decode, GPR/bitmap read, immediate sign-extend, ID/EX register with
// load-use interlock, flush and saturating stall counter. 1-cycle latency; holds while !ex_ready.
// Optional macro DEC_BYPASS_EN: write-first GPR reads from writeback (default read-first).

module controller (
  input  logic [3:0] op_i,
  output logic       mux_read_reg1_o,
  output logic [1:0] mux_read_reg2_o,
  output logic       mux_write_reg_o,
  output logic [1:0] mux_read_bm_o,
  output logic [1:0] sign_ex_o,
  output logic       reg_write_o,
  output logic       bm_write_o,
  output logic       dmem_write_o,
  output logic       dmem_en_o,
  output logic       rs1_used_o,
  output logic       rs2_used_o
);
  always_comb begin
    mux_read_reg1_o = 1'b0;
    mux_read_reg2_o = 2'b00;
    mux_write_reg_o = 1'b0;
    mux_read_bm_o   = 2'b00;
    sign_ex_o       = 2'b00;
    reg_write_o     = 1'b0;
    bm_write_o      = 1'b0;
    dmem_write_o    = 1'b0;
    dmem_en_o       = 1'b0;
    rs1_used_o      = 1'b0;
    rs2_used_o      = 1'b0;
    case (op_i)
      4'h1, 4'h2: begin // ADD, SUB
        mux_write_reg_o = 1'b1;
        reg_write_o     = 1'b1;
        rs1_used_o      = 1'b1;
        rs2_used_o      = 1'b1;
      end
      4'h3: begin // ADDI
        mux_write_reg_o = 1'b1;
        sign_ex_o       = 2'b11;
        reg_write_o     = 1'b1;
        rs1_used_o      = 1'b1;
      end
      4'h4: begin // LDI
        mux_write_reg_o = 1'b1;
        sign_ex_o       = 2'b01;
        reg_write_o     = 1'b1;
      end
      4'h5, 4'hA: begin // LD, LDB
        mux_write_reg_o = 1'b1;
        sign_ex_o       = 2'b11;
        reg_write_o     = 1'b1;
        dmem_en_o       = 1'b1;
        rs1_used_o      = 1'b1;
      end
      4'h6: begin // ST: data register sits in the dest field
        mux_read_reg2_o = 2'b11;
        sign_ex_o       = 2'b11;
        dmem_en_o       = 1'b1;
        dmem_write_o    = 1'b1;
        rs1_used_o      = 1'b1;
        rs2_used_o      = 1'b1;
      end
      4'h8: begin // JR
        mux_read_reg1_o = 1'b1;
        rs1_used_o      = 1'b1;
      end
      4'h9: begin // LDIS
        sign_ex_o   = 2'b10;
        reg_write_o = 1'b1;
      end
      4'hB: begin // BMOV
        mux_read_bm_o = 2'b01;
        bm_write_o    = 1'b1;
      end
      4'hC: begin // BST
        mux_read_bm_o   = 2'b10;
        mux_read_reg1_o = 1'b1;
        dmem_en_o       = 1'b1;
        dmem_write_o    = 1'b1;
        rs1_used_o      = 1'b1;
      end
      4'hD: begin // BCNT
        mux_read_reg2_o = 2'b10;
        reg_write_o     = 1'b1;
        rs2_used_o      = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

module dec_stage_pipe #(
  parameter  int DATA_W = 16,
  parameter  int NREG   = 16,
  parameter  int NBM    = 4,
  parameter  int BM_W   = 1536,
  parameter  int CNT_W  = 16,
  localparam int RA_W   = ($clog2(NREG) < 4) ? 4 : $clog2(NREG),
  localparam int BA_W   = ($clog2(NBM) < 2) ? 2 : $clog2(NBM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       inst,
  input  logic              wb_reg_en,
  input  logic [RA_W-1:0]   wb_reg_addr,
  input  logic [DATA_W-1:0] wb_reg_data,
  input  logic              wb_bm_en,
  input  logic [BA_W-1:0]   wb_bm_addr,
  input  logic [BM_W-1:0]   wb_bm_data,
  input  logic              ex_ld_valid,
  input  logic [RA_W-1:0]   ex_ld_dest,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              out_valid,
  output logic [3:0]        out_op,
  output logic [2:0]        out_pnz,
  output logic [RA_W-1:0]   out_rs1_addr,
  output logic [RA_W-1:0]   out_rs2_addr,
  output logic [RA_W-1:0]   out_dest,
  output logic [DATA_W-1:0] out_rs1_data,
  output logic [DATA_W-1:0] out_rs2_data,
  output logic [BA_W-1:0]   out_bm_addr,
  output logic [BA_W-1:0]   out_wbm_addr,
  output logic [BM_W-1:0]   out_bm_data,
  output logic [DATA_W-1:0] out_imm,
  output logic              out_reg_write,
  output logic              out_bm_write,
  output logic              out_dmem_write,
  output logic              out_dmem_en,
  output logic [CNT_W-1:0]  stall_cnt
);
  typedef struct packed {
    logic [3:0]        op;
    logic [2:0]        pnz;
    logic [RA_W-1:0]   rs1_addr;
    logic [RA_W-1:0]   rs2_addr;
    logic [RA_W-1:0]   dest;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [BA_W-1:0]   bm_addr;
    logic [BA_W-1:0]   wbm_addr;
    logic [BM_W-1:0]   bm_data;
    logic [DATA_W-1:0] imm;
    logic              reg_write;
    logic              bm_write;
    logic              dmem_write;
    logic              dmem_en;
  } idex_t;

  logic              mrr1, mwr, reg_write, bm_write, dmem_write, dmem_en, rs1_used, rs2_used;
  logic [1:0]        mrr2, mrbm, sign_ex;
  logic [RA_W-1:0]   rs1_addr, rs2_addr, dest;
  logic [BA_W-1:0]   bm_addr;
  logic [DATA_W-1:0] rs1_data, rs2_data, imm;
  logic [BM_W-1:0]   bm_data;
  logic              hz, adv;

  logic [DATA_W-1:0] gpr_q [NREG];
  logic [BM_W-1:0]   bm_q  [NBM];
  idex_t             bundle_q, bundle_d, dec;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  controller u_ctrl (
    .op_i            (inst[15:12]),
    .mux_read_reg1_o (mrr1),
    .mux_read_reg2_o (mrr2),
    .mux_write_reg_o (mwr),
    .mux_read_bm_o   (mrbm),
    .sign_ex_o       (sign_ex),
    .reg_write_o     (reg_write),
    .bm_write_o      (bm_write),
    .dmem_write_o    (dmem_write),
    .dmem_en_o       (dmem_en),
    .rs1_used_o      (rs1_used),
    .rs2_used_o      (rs2_used)
  );

  always_comb begin
    rs1_addr = mrr1 ? RA_W'(inst[9:6]) : RA_W'(inst[7:4]);
    case (mrr2)
      2'b11:   rs2_addr = RA_W'(inst[11:8]);
      2'b10:   rs2_addr = RA_W'(inst[5:2]);
      default: rs2_addr = RA_W'(inst[3:0]);
    endcase
    dest = mwr ? RA_W'(inst[11:8]) : RA_W'(inst[9:6]);
    case (mrbm)
      2'b00:   bm_addr = BA_W'(inst[1:0]);
      2'b01:   bm_addr = BA_W'(inst[8:7]);
      default: bm_addr = BA_W'(inst[11:10]);
    endcase
    case (sign_ex)
      2'b11:   imm = {{(DATA_W-4){inst[3]}}, inst[3:0]};
      2'b10:   imm = {{(DATA_W-6){inst[5]}}, inst[5:0]};
      2'b01:   imm = {{(DATA_W-8){inst[7]}}, inst[7:0]};
      default: imm = {{(DATA_W-9){inst[8]}}, inst[8:0]};
    endcase
  end

`ifdef DEC_BYPASS_EN
  assign rs1_data = (wb_reg_en && !rst && wb_reg_addr == rs1_addr) ? wb_reg_data : gpr_q[rs1_addr];
  assign rs2_data = (wb_reg_en && !rst && wb_reg_addr == rs2_addr) ? wb_reg_data : gpr_q[rs2_addr];
`else
  assign rs1_data = gpr_q[rs1_addr];
  assign rs2_data = gpr_q[rs2_addr];
`endif
  assign bm_data = (wb_bm_en && wb_bm_addr == bm_addr) ? wb_bm_data : bm_q[bm_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) gpr_q[i] <= '0;
    end else if (wb_reg_en) begin
      gpr_q[wb_reg_addr] <= wb_reg_data;
    end
  end

  // Bitmap contents survive reset; only the write port updates them.
  always_ff @(posedge clk) begin
    if (wb_bm_en) bm_q[wb_bm_addr] <= wb_bm_data;
  end

  assign hz = in_valid && ex_ld_valid &&
              ((rs1_used && ex_ld_dest == rs1_addr) || (rs2_used && ex_ld_dest == rs2_addr));
  assign adv      = !valid_q || ex_ready;
  assign in_ready = adv && !hz && !flush && !rst;

  always_comb begin
    dec = '{op: inst[15:12], pnz: inst[11:9], rs1_addr: rs1_addr, rs2_addr: rs2_addr,
            dest: dest, rs1_data: rs1_data, rs2_data: rs2_data, bm_addr: bm_addr,
            wbm_addr: BA_W'(inst[11:10]), bm_data: bm_data, imm: imm,
            reg_write: reg_write, bm_write: bm_write, dmem_write: dmem_write, dmem_en: dmem_en};
    bundle_d = bundle_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (adv && hz) begin
      valid_d = 1'b0;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else if (in_valid && in_ready) begin
      bundle_d = dec;
      valid_d  = 1'b1;
    end else if (adv) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bundle_q <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      bundle_q <= bundle_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_op         = bundle_q.op;
  assign out_pnz        = bundle_q.pnz;
  assign out_rs1_addr   = bundle_q.rs1_addr;
  assign out_rs2_addr   = bundle_q.rs2_addr;
  assign out_dest       = bundle_q.dest;
  assign out_rs1_data   = bundle_q.rs1_data;
  assign out_rs2_data   = bundle_q.rs2_data;
  assign out_bm_addr    = bundle_q.bm_addr;
  assign out_wbm_addr   = bundle_q.wbm_addr;
  assign out_bm_data    = bundle_q.bm_data;
  assign out_imm        = bundle_q.imm;
  assign out_reg_write  = bundle_q.reg_write;
  assign out_bm_write   = bundle_q.bm_write;
  assign out_dmem_write = bundle_q.dmem_write;
  assign out_dmem_en    = bundle_q.dmem_en;
  assign stall_cnt      = cnt_q;
endmodule
